axi2apb_bridge_mc: RTL

- Parametrised successor of the single-port AXI-to-APB bridge.
- Converts AXI3 bursts (FIXED/INCR, up to 16 beats) into sequences of APB transfers across NUM_SLAVES decoded APB slaves. Buffers write data in an internal FIFO.
- Arbitrates read vs write round-robin and returns DECERR/SLVERR per AXI rules.
- Sits between the AXI interconnect and the peripheral APB segment. One transaction in flight at a time.

---
 rtl/axi2apb_bridge_mc.sv | 319 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi2apb_bridge_mc.sv
// AXI3 (FIXED/INCR, up to 16 beats) to multi-slave APB bridge with a write-data FIFO.
// Optional feature: define AXI2APB_TIMEOUT_EN to bound each APB access at 1024 wait cycles.
module axi2apb_bridge_mc #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 4,
    parameter int NUM_SLAVES      = 4,
    parameter int SEL_LSB         = 12,
    parameter int WFIFO_DEPTH_LG2 = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ID_WIDTH-1:0]              awid_i,
    input  logic [ADDR_WIDTH-1:0]            awaddr_i,
    input  logic [3:0]                       awlen_i,
    input  logic [2:0]                       awsize_i,
    input  logic [1:0]                       awburst_i,
    input  logic                             awvalid_i,
    output logic                             awready_o,
    input  logic [DATA_WIDTH-1:0]            wdata_i,
    input  logic [DATA_WIDTH/8-1:0]          wstrb_i,
    input  logic                             wlast_i,
    input  logic                             wvalid_i,
    output logic                             wready_o,
    output logic [ID_WIDTH-1:0]              bid_o,
    output logic [1:0]                       bresp_o,
    output logic                             bvalid_o,
    input  logic                             bready_i,
    input  logic [ID_WIDTH-1:0]              arid_i,
    input  logic [ADDR_WIDTH-1:0]            araddr_i,
    input  logic [3:0]                       arlen_i,
    input  logic [2:0]                       arsize_i,
    input  logic [1:0]                       arburst_i,
    input  logic                             arvalid_i,
    output logic                             arready_o,
    output logic [ID_WIDTH-1:0]              rid_o,
    output logic [DATA_WIDTH-1:0]            rdata_o,
    output logic [1:0]                       rresp_o,
    output logic                             rlast_o,
    output logic                             rvalid_o,
    input  logic                             rready_i,
    output logic [ADDR_WIDTH-1:0]            paddr_o,
    output logic [DATA_WIDTH-1:0]            pwdata_o,
    output logic [DATA_WIDTH/8-1:0]          pstrb_o,
    output logic                             pwrite_o,
    output logic                             penable_o,
    output logic [NUM_SLAVES-1:0]            psel_o,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata_i,
    input  logic [NUM_SLAVES-1:0]            pready_i,
    input  logic [NUM_SLAVES-1:0]            pslverr_i
);
    // state  | meaning
    // IDLE   | no transaction; AW/AR arbitration and handshake
    // SETUP  | APB setup phase (DECERR bursts drain/answer beats here)
    // ACCESS | APB access phase, waiting for pready
    // RDATA  | R beat presented, waiting for rready
    // BRESP  | B response presented, waiting for bready
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_RDATA, S_BRESP} state_t;

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int DEPTH      = 1 << WFIFO_DEPTH_LG2;
    localparam int CNT_W      = WFIFO_DEPTH_LG2 + 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    state_t                    state_q, state_d;
    logic [ID_WIDTH-1:0]       id_q, id_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [3:0]                len_q, len_d;
    logic [2:0]                size_q, size_d;
    logic [1:0]                burst_q, burst_d;
    logic [3:0]                beat_q, beat_d;
    logic [1:0]                err_q, err_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      dec_q, dec_d;
    logic                      is_wr_q, is_wr_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic [1:0]                rresp_q, rresp_d;
    logic                      last_wr_q, last_wr_d;
    logic                      wr_active_q;

    logic [DATA_WIDTH-1:0]      fifo_data_q [DEPTH];
    logic [STRB_WIDTH-1:0]      fifo_strb_q [DEPTH];
    logic [WFIFO_DEPTH_LG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]           count_q;
    logic                       fifo_empty, fifo_full, fifo_push, fifo_pop;

    logic                      grant_wr;
    logic [ADDR_WIDTH-1:0]     a_addr;
    logic [IDX_W-1:0]          a_idx;
    logic                      a_dec;
    logic [ADDR_WIDTH-1:0]     addr_next;
    logic                      last_beat, apb_phase;
    logic [NUM_SLAVES-1:0]     sel_onehot;
    logic                      sel_pready, sel_slverr;
    logic [DATA_WIDTH-1:0]     sel_rdata;
    logic                      timed_out, beat_done, beat_err;

    // Write when it is the only request, or when both request and read was served last.
    assign grant_wr  = awvalid_i && (!arvalid_i || !last_wr_q);
    assign awready_o = (state_q == S_IDLE) && grant_wr;
    assign arready_o = (state_q == S_IDLE) && arvalid_i && !grant_wr;

    assign a_addr = grant_wr ? awaddr_i : araddr_i;
    assign a_idx  = a_addr[SEL_LSB +: IDX_W];
    assign a_dec  = ({1'b0, a_idx} >= (IDX_W + 1)'(NUM_SLAVES)) ||
                    ((a_addr >> (SEL_LSB + IDX_W)) != '0);

    assign addr_next = (burst_q == 2'b00) ? addr_q : addr_q + (ADDR_WIDTH'(1) << size_q);
    assign last_beat = (beat_q == len_q);

    always_comb begin
        sel_onehot = '0;
        sel_pready = 1'b0;
        sel_slverr = 1'b0;
        sel_rdata  = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (idx_q == IDX_W'(k)) begin
                sel_onehot[k] = 1'b1;
                sel_pready    = pready_i[k];
                sel_slverr    = pslverr_i[k];
                sel_rdata     = prdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign wready_o   = wr_active_q && !fifo_full;
    assign fifo_push  = wvalid_i && wready_o;

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_data_q[wr_ptr_q] <= wdata_i;
            fifo_strb_q[wr_ptr_q] <= wstrb_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_active_q <= 1'b0;
        end else begin
            if (fifo_push) wr_ptr_q <= wr_ptr_q + WFIFO_DEPTH_LG2'(1);
            if (fifo_pop)  rd_ptr_q <= rd_ptr_q + WFIFO_DEPTH_LG2'(1);
            if (fifo_push && !fifo_pop)      count_q <= count_q + CNT_W'(1);
            else if (!fifo_push && fifo_pop) count_q <= count_q - CNT_W'(1);
            // A new AW opens the W window; the beat carrying wlast closes it.
            if (awvalid_i && awready_o)      wr_active_q <= 1'b1;
            else if (fifo_push && wlast_i)   wr_active_q <= 1'b0;
        end
    end

`ifdef AXI2APB_TIMEOUT_EN
    logic [15:0] to_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else if (state_q == S_SETUP) begin
            to_cnt_q <= 16'd1023;
        end else if ((state_q == S_ACCESS) && (to_cnt_q != '0)) begin
            to_cnt_q <= to_cnt_q - 16'd1;
        end
    end

    assign timed_out = (state_q == S_ACCESS) && !sel_pready && (to_cnt_q == '0);
`else
    assign timed_out = 1'b0;
`endif

    assign beat_done = sel_pready || timed_out;
    assign beat_err  = (sel_pready && sel_slverr) || timed_out;

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        beat_d    = beat_q;
        err_d     = err_q;
        idx_d     = idx_q;
        dec_d     = dec_q;
        is_wr_d   = is_wr_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        last_wr_d = last_wr_q;
        fifo_pop  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (awready_o || arready_o) begin
                    is_wr_d   = awready_o;
                    last_wr_d = awready_o;
                    id_d      = awready_o ? awid_i    : arid_i;
                    len_d     = awready_o ? awlen_i   : arlen_i;
                    size_d    = awready_o ? awsize_i  : arsize_i;
                    burst_d   = awready_o ? awburst_i : arburst_i;
                    addr_d    = a_addr;
                    idx_d     = a_idx;
                    dec_d     = a_dec;
                    beat_d    = '0;
                    err_d     = a_dec ? RESP_DECERR : RESP_OKAY;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                if (dec_q) begin
                    if (!is_wr_q) begin
                        rdata_d = '0;
                        rresp_d = RESP_DECERR;
                        state_d = S_RDATA;
                    end else if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        if (last_beat) state_d = S_BRESP;
                        else           beat_d  = beat_q + 4'd1;
                    end
                end else if (!(is_wr_q && fifo_empty)) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (beat_done) begin
                    if (is_wr_q) begin
                        fifo_pop = 1'b1;
                        if (beat_err) err_d = RESP_SLVERR;
                        if (last_beat) begin
                            state_d = S_BRESP;
                        end else begin
                            beat_d  = beat_q + 4'd1;
                            addr_d  = addr_next;
                            state_d = S_SETUP;
                        end
                    end else begin
                        rdata_d = timed_out ? '0 : sel_rdata;
                        rresp_d = beat_err ? RESP_SLVERR : RESP_OKAY;
                        state_d = S_RDATA;
                    end
                end
            end
            S_RDATA: begin
                if (rready_i) begin
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end else begin
                        beat_d  = beat_q + 4'd1;
                        addr_d  = addr_next;
                        state_d = S_SETUP;
                    end
                end
            end
            S_BRESP: begin
                if (bready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            beat_q    <= '0;
            err_q     <= RESP_OKAY;
            idx_q     <= '0;
            dec_q     <= 1'b0;
            is_wr_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            last_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            beat_q    <= beat_d;
            err_q     <= err_d;
            idx_q     <= idx_d;
            dec_q     <= dec_d;
            is_wr_q   <= is_wr_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            last_wr_q <= last_wr_d;
        end
    end

    // A write holds off its setup phase until the FIFO has the beat's data.
    assign apb_phase = !dec_q && ((state_q == S_ACCESS) ||
                                  ((state_q == S_SETUP) && !(is_wr_q && fifo_empty)));

    assign psel_o    = apb_phase ? sel_onehot : '0;
    assign penable_o = apb_phase && (state_q == S_ACCESS);
    assign pwrite_o  = apb_phase && is_wr_q;
    assign paddr_o   = apb_phase ? addr_q : '0;
    assign pwdata_o  = (apb_phase && is_wr_q) ? fifo_data_q[rd_ptr_q] : '0;
    assign pstrb_o   = (apb_phase && is_wr_q) ? fifo_strb_q[rd_ptr_q] : '0;

    assign rvalid_o  = (state_q == S_RDATA);
    assign rid_o     = rvalid_o ? id_q : '0;
    assign rdata_o   = rvalid_o ? rdata_q : '0;
    assign rresp_o   = rvalid_o ? rresp_q : '0;
    assign rlast_o   = rvalid_o && last_beat;

    assign bvalid_o  = (state_q == S_BRESP);
    assign bid_o     = bvalid_o ? id_q : '0;
    assign bresp_o   = bvalid_o ? err_q : '0;

endmodule
